// File: rtl/wavetable_gen.sv
// wavetable_gen: three-stage, voice-tagged oscillator stage.
// Turns one (voice, phase, waveform) request per clock into one signed sample
// three non-stalled clocks later. Waveforms: sine (quarter-wave ROM), square
// with variable duty, saw, triangle, and silence.
// Optional noise source: define WAVETABLE_GEN_NOISE_EN to build a 16-bit
// Galois LFSR for select 4; otherwise select 4 is silence.
module wavetable_gen #(
    parameter int PHASE_W  = 10,
    parameter int SAMPLE_W = 16,
    parameter int VOICE_W  = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_stall,
    input  logic [PHASE_W-1:0]  i_phase,
    input  logic [2:0]          i_wave_select,
    input  logic [PHASE_W-1:0]  i_pulse_width,
    input  logic [VOICE_W-1:0]  i_voice_index,
    output logic                o_valid,
    output logic [VOICE_W-1:0]  o_voice_index,
    output logic [SAMPLE_W-1:0] o_sample
);

    localparam int ADDR_W    = PHASE_W - 2;
    localparam int ROM_DEPTH = 1 << ADDR_W;
    localparam int MAG_W     = SAMPLE_W - 1;

    localparam logic [2:0] WAVE_SINE   = 3'd0;
    localparam logic [2:0] WAVE_SQUARE = 3'd1;
    localparam logic [2:0] WAVE_SAW    = 3'd2;
    localparam logic [2:0] WAVE_TRI    = 3'd3;
    localparam logic [2:0] WAVE_NOISE  = 3'd4;

    localparam logic [SAMPLE_W-1:0] NEG_MIN = {1'b1, {MAG_W{1'b0}}};
    localparam logic [SAMPLE_W-1:0] POS_MAX = ~NEG_MIN;

    // Quarter-wave entry k, sampled at the centre of its phase bin so the
    // table never hits exactly zero and mirrors cleanly across quadrants.
    function automatic logic [MAG_W-1:0] sine_entry(input int k);
        real angle;
        real amp;
        angle = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(ROM_DEPTH);
        amp   = real'((1 << MAG_W) - 1) * $sin(angle);
        return MAG_W'($rtoi(amp + 0.5));
    endfunction

    logic [MAG_W-1:0] rom [ROM_DEPTH];
    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        assign rom[k] = sine_entry(k);
    end

    // ---------------- Stage 1 registers ----------------
    logic                s1_valid;
    logic [PHASE_W-1:0]  s1_phase;
    logic [2:0]          s1_sel;
    logic [PHASE_W-1:0]  s1_pw;
    logic [VOICE_W-1:0]  s1_voice;

`ifdef WAVETABLE_GEN_NOISE_EN
    logic [15:0]         lfsr;
    logic [15:0]         s1_noise;
    logic [SAMPLE_W-1:0] noise_ext;

    // Advance the LFSR once per accepted noise request; reset beats stall.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lfsr <= 16'hACE1;
        end else if (!i_stall && i_valid && i_wave_select == WAVE_NOISE) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign noise_ext = SAMPLE_W'($signed(s1_noise));
`endif

    // Stage 1 valid bit; reset discards whatever is in flight.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of block ordering.
        if (i_reset) begin
            s1_valid <= 1'b0;
        end else if (!i_stall) begin
            s1_valid <= i_valid;
        end
    end

    // Stage 1 payload capture (data qualified by s1_valid downstream).
    always_ff @(posedge i_clk) begin
        // NOTE: payload registers and the ROM carry no reset; only valid bits
        // and the visible outputs need a defined value.
        if (!i_stall) begin
            s1_phase <= i_phase;
            s1_sel   <= i_wave_select;
            s1_pw    <= i_pulse_width;
            s1_voice <= i_voice_index;
`ifdef WAVETABLE_GEN_NOISE_EN
            s1_noise <= lfsr;
`endif
        end
    end

    // Quadrant decode and ROM address: mirror the address in odd quadrants.
    logic [ADDR_W-1:0] rom_addr;
    assign rom_addr = s1_phase[PHASE_W-2] ? ~s1_phase[ADDR_W-1:0]
                                          :  s1_phase[ADDR_W-1:0];

    // Phase left-justified to sample width.
    logic [SAMPLE_W-1:0] u;
    if (PHASE_W >= SAMPLE_W) begin : g_u_trunc
        assign u = s1_phase[PHASE_W-1 -: SAMPLE_W];
    end else begin : g_u_pad
        assign u = {s1_phase, {(SAMPLE_W-PHASE_W){1'b0}}};
    end

    // Non-sine waveform values computed from the stage 1 registers.
    logic [SAMPLE_W-1:0] wave_next;
    logic [SAMPLE_W-1:0] tri_v;
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        wave_next = '0;
        tri_v     = {u[SAMPLE_W-2:0], 1'b0};
        if (s1_phase[PHASE_W-1]) begin
            tri_v = ~tri_v;
        end
        case (s1_sel)
            WAVE_SQUARE: wave_next = (s1_phase < s1_pw) ? POS_MAX : NEG_MIN;
            WAVE_SAW:    wave_next = u ^ NEG_MIN;
            WAVE_TRI:    wave_next = tri_v ^ NEG_MIN;
`ifdef WAVETABLE_GEN_NOISE_EN
            WAVE_NOISE:  wave_next = noise_ext;
`endif
            default:     wave_next = '0;
        endcase
    end

    // ---------------- Stage 2 registers ----------------
    logic                s2_valid;
    logic                s2_is_sine;
    logic                s2_neg;
    logic [MAG_W-1:0]    s2_mag;
    logic [SAMPLE_W-1:0] s2_wave;
    logic [VOICE_W-1:0]  s2_voice;

    // Stage 2 valid bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_valid <= 1'b0;
        end else if (!i_stall) begin
            s2_valid <= s1_valid;
        end
    end

    // Stage 2 payload: synchronous ROM read plus precomputed waveform.
    always_ff @(posedge i_clk) begin
        if (!i_stall) begin
            s2_mag     <= rom[rom_addr];
            s2_is_sine <= (s1_sel == WAVE_SINE);
            s2_neg     <= s1_phase[PHASE_W-1];
            s2_wave    <= wave_next;
            s2_voice   <= s1_voice;
        end
    end

    // ---------------- Stage 3 / outputs ----------------
    logic [SAMPLE_W-1:0] sine_val;
    assign sine_val = {1'b0, s2_mag};

    // Output stage: sign the sine, select the sample; data holds on bubbles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid       <= 1'b0;
            o_voice_index <= '0;
            o_sample      <= '0;
        end else if (!i_stall) begin
            o_valid <= s2_valid;
            if (s2_valid) begin
                o_voice_index <= s2_voice;
                if (s2_is_sine) begin
                    o_sample <= s2_neg ? -sine_val : sine_val;
                end else begin
                    o_sample <= s2_wave;
                end
            end
        end
    end

endmodule

// File: tb/tb_wavetable_gen.sv
// Scoreboard bench for wavetable_gen: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares whenever o_valid is seen.
module tb_wavetable_gen;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        i_stall;
    logic [9:0]  i_phase;
    logic [2:0]  i_wave_select;
    logic [9:0]  i_pulse_width;
    logic [7:0]  i_voice_index;
    logic        o_valid;
    logic [7:0]  o_voice_index;
    logic [15:0] o_sample;

    localparam logic [2:0] SINE = 3'd0, SQ = 3'd1, SAW = 3'd2, TRI = 3'd3, NOISE = 3'd4;

`ifdef WAVETABLE_GEN_NOISE_EN
    localparam logic [15:0] NOISE0 = 16'hACE1;
    localparam logic [15:0] NOISE1 = 16'hE270;
`else
    localparam logic [15:0] NOISE0 = 16'h0000;
    localparam logic [15:0] NOISE1 = 16'h0000;
`endif

    wavetable_gen #(.PHASE_W(10), .SAMPLE_W(16), .VOICE_W(8)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_stall       (i_stall),
        .i_phase       (i_phase),
        .i_wave_select (i_wave_select),
        .i_pulse_width (i_pulse_width),
        .i_voice_index (i_voice_index),
        .o_valid       (o_valid),
        .o_voice_index (o_voice_index),
        .o_sample      (o_sample)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sample;
        logic [7:0]  voice;
        int          tick;
    } item_t;

    item_t       sb[$];
    int          total = 0;
    int          bad = 0;
    int          tick = 0;
    logic        edge_rst = 1'b0;
    logic        edge_adv = 1'b0;
    logic        started = 1'b0;
    logic [15:0] last_sample = '0;
    logic [7:0]  last_voice = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record what happened at each posedge: reset, advance, or stall.
    always @(posedge clk) begin
        edge_rst <= i_reset;
        edge_adv <= !i_stall && !i_reset;
        if (i_reset) started <= 1'b1;
        if (!i_stall && !i_reset) tick <= tick + 1;
    end

    // Monitor: compare outputs half a cycle after each edge.
    always @(negedge clk) begin
        if (started) begin
            if (edge_rst) begin
                check("reset_valid", 32'(o_valid), 32'd0);
                check("reset_sample", 32'(o_sample), 32'd0);
                check("reset_voice", 32'(o_voice_index), 32'd0);
                sb.delete();
                last_sample = '0;
                last_voice  = '0;
            end else if (!edge_adv) begin
                check("stall_hold_sample", 32'(o_sample), 32'(last_sample));
                check("stall_hold_voice", 32'(o_voice_index), 32'(last_voice));
            end else if (o_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got voice 0x%0h sample 0x%0h want no output",
                             o_voice_index, o_sample);
                end else begin
                    item_t it;
                    it = sb.pop_front();
                    check("sample", 32'(o_sample), 32'(it.sample));
                    check("voice", 32'(o_voice_index), 32'(it.voice));
                    check("latency", 32'(tick - it.tick), 32'd3);
                    last_sample = it.sample;
                    last_voice  = it.voice;
                end
            end else begin
                check("bubble_hold_sample", 32'(o_sample), 32'(last_sample));
                check("bubble_hold_voice", 32'(o_voice_index), 32'(last_voice));
            end
        end
    end

    task automatic issue(input logic [2:0] sel, input logic [9:0] ph, input logic [9:0] pw,
                         input logic [7:0] v, input logic [15:0] exp);
        item_t it;
        @(negedge clk);
        i_valid       = 1'b1;
        i_stall       = 1'b0;
        i_wave_select = sel;
        i_phase       = ph;
        i_pulse_width = pw;
        i_voice_index = v;
        it.sample = exp;
        it.voice  = v;
        it.tick   = tick;
        sb.push_back(it);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_stall = 1'b0;
        end
    endtask

    // Stall with a junk request on the inputs; it must not be accepted.
    task automatic stall(input int n);
        repeat (n) begin
            @(negedge clk);
            i_stall       = 1'b1;
            i_valid       = 1'b1;
            i_wave_select = SAW;
            i_phase       = 10'd77;
            i_voice_index = 8'hEE;
        end
    endtask

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_stall = 1'b0; i_phase = '0;
        i_wave_select = '0; i_pulse_width = '0; i_voice_index = '0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;

        // Sine quadrant points, back-to-back.
        issue(SINE, 10'd0,   10'd0, 8'd1, 16'h0065);
        issue(SINE, 10'd256, 10'd0, 8'd2, 16'h7FFF);
        issue(SINE, 10'd512, 10'd0, 8'd3, 16'hFF9B);
        issue(SINE, 10'd768, 10'd0, 8'd4, 16'h8001);
        idle(4);

        // Triangle corners and saw endpoints.
        issue(TRI, 10'd0,    10'd0, 8'd5,  16'h8000);
        issue(TRI, 10'd256,  10'd0, 8'd6,  16'h0000);
        issue(TRI, 10'd512,  10'd0, 8'd7,  16'h7FFF);
        issue(TRI, 10'd768,  10'd0, 8'd8,  16'hFFFF);
        issue(SAW, 10'd0,    10'd0, 8'd9,  16'h8000);
        issue(SAW, 10'd1023, 10'd0, 8'd10, 16'h7FC0);
        idle(4);

        // Square duty threshold and zero pulse width.
        issue(SQ, 10'd299, 10'd300, 8'd11, 16'h7FFF);
        issue(SQ, 10'd300, 10'd300, 8'd12, 16'h8000);
        issue(SQ, 10'd0,   10'd0,   8'd13, 16'h8000);
        idle(4);

        // Stream with a bubble and a two-cycle stall.
        issue(TRI,  10'd256,  10'd0,   8'd20, 16'h0000);
        issue(SAW,  10'd1023, 10'd0,   8'd21, 16'h7FC0);
        idle(1);
        stall(2);
        issue(SQ,   10'd0,    10'd300, 8'd22, 16'h7FFF);
        issue(SINE, 10'd768,  10'd0,   8'd23, 16'h8001);
        issue(3'd6, 10'd5,    10'd0,   8'd24, 16'h0000);
        idle(5);

        // Reset (with stall also high) while requests are in flight.
        issue(SAW,  10'd0,   10'd0, 8'd30, 16'h8000);
        issue(SINE, 10'd256, 10'd0, 8'd31, 16'h7FFF);
        issue(TRI,  10'd512, 10'd0, 8'd32, 16'h7FFF);
        @(negedge clk);
        i_reset = 1'b1;
        i_stall = 1'b1;
        i_valid = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        i_stall = 1'b0;
        i_valid = 1'b0;
        idle(4);

        // Noise right after reset (silence when the LFSR is not built).
        issue(NOISE, 10'd0, 10'd0, 8'd40, NOISE0);
        issue(NOISE, 10'd9, 10'd0, 8'd41, NOISE1);
        idle(8);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
